// File: rtl/fault_supervisor_pkg.sv
// Shared constants and helpers for the power-unit fault path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: board fault channel indices, trip counter ceiling, lowest_set_idx().
package fault_supervisor_pkg;

  // Board fault channel assignment, polarity already corrected upstream.
  localparam int CH_IGBT0   = 0;
  localparam int CH_IGBT1   = 1;
  localparam int CH_IGBT2   = 2;
  localparam int CH_IGBT3   = 3;
  localparam int CH_DCOV    = 4;
  localparam int CH_DCUV    = 5;
  localparam int CH_HOT1    = 6;
  localparam int CH_HOT2    = 7;
  localparam int CH_PWRFALL = 8;
  localparam int CH_BYPPWR  = 9;
  localparam int CH_SOFTOV  = 10;
  localparam int CH_SOFTUV  = 11;

  localparam logic [7:0] FAULT_CNT_MAX = 8'd255;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fault_supervisor_if.sv
// Bundle of fault inputs/controls and supervisor status outputs.
// Latency: n/a (wires only).
// Backpressure: none, all signals are levels or single-cycle strobes.
// Ports: time_1us, reset_unit, fault_raw, fault_mask, byp_en_mask (to supervisor);
//        err_info, err_unit, first_valid, first_id, fault_cnt, byp_req (from supervisor).
interface fault_supervisor_if #(
  parameter int N_CH = 12
) ();
  localparam int IDW = $clog2(N_CH);

  logic            time_1us;
  logic            reset_unit;
  logic [N_CH-1:0] fault_raw;
  logic [N_CH-1:0] fault_mask;
  logic [N_CH-1:0] byp_en_mask;

  logic [N_CH-1:0] err_info;
  logic            err_unit;
  logic            first_valid;
  logic [IDW-1:0]  first_id;
  logic [7:0]      fault_cnt;
  logic            byp_req;

  // master drives the fault inputs and reads status; slave is the supervisor.
  modport master (
    output time_1us, reset_unit, fault_raw, fault_mask, byp_en_mask,
    input  err_info, err_unit, first_valid, first_id, fault_cnt, byp_req
  );

  modport slave (
    input  time_1us, reset_unit, fault_raw, fault_mask, byp_en_mask,
    output err_info, err_unit, first_valid, first_id, fault_cnt, byp_req
  );
endinterface

// File: rtl/fault_supervisor_debounce_ch.sv
// One fault channel: tick-based debounce counter plus sticky latch with clear.
// Latency: latch sets on the DEB_US-th consecutive qualified tick edge.
// Backpressure: none; clr dominates and blocks any set in the same cycle.
// Ports: clk, rst_n, tick, clr, raw, mask in; err (latched flag), set (1 on the latching edge) out.
module fault_debounce_ch #(
  parameter int CNT_W  = 14,
  parameter int DEB_US = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  input  logic raw,
  input  logic mask,
  output logic err,
  output logic set
);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_US);

  logic [CNT_W-1:0] cnt;
  logic             qual;
  logic             hit;

  assign qual = raw & ~mask;
  // Counter is about to reach DEB_MAX on this edge.
  assign hit  = tick & qual & (cnt == DEB_MAX - 1'b1);
  assign set  = hit & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (tick) begin
        if (!qual)               cnt <= '0;
        else if (cnt != DEB_MAX) cnt <= cnt + 1'b1;
      end
      if (hit) err <= 1'b1;
    end
  end
endmodule

// File: rtl/fault_supervisor.sv
// Fault supervisor: per-channel debounce/latch, first-fault capture, trip counter, bypass timer.
// Latency: err_info/first_*/fault_cnt update on the latching edge; err_unit is combinational from latches.
// Backpressure: none; reset_unit clears latches and first-fault record but never fault_cnt/byp_req.
// Ports: clk, rst_n plain; all fault inputs and status outputs via fault_supervisor_if.slave.
module fault_supervisor
  import fault_supervisor_pkg::*;
#(
  parameter int N_CH       = 12,
  parameter int CNT_W      = 14,
  parameter int DEB_US     = 5,
  parameter int BYP_DLY_US = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fault_supervisor_if.slave     bus
);
  localparam int IDW = $clog2(N_CH);
  localparam logic [CNT_W-1:0] BYP_MAX = CNT_W'(BYP_DLY_US);

  logic [N_CH-1:0]  err_q;
  logic [N_CH-1:0]  set_vec;
  logic [N_CH-1:0]  new_vec;
  logic             first_valid_q;
  logic [IDW-1:0]   first_id_q;
  logic [7:0]       fault_cnt_q;
  logic [CNT_W-1:0] btmr;
  logic             byp_req_q;
  logic             byp_arm;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fault_debounce_ch #(
      .CNT_W  (CNT_W),
      .DEB_US (DEB_US)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (bus.time_1us),
      .clr   (bus.reset_unit),
      .raw   (bus.fault_raw[i]),
      .mask  (bus.fault_mask[i]),
      .err   (err_q[i]),
      .set   (set_vec[i])
    );
  end

  // Only channels not already latched count as a new trip.
  assign new_vec = set_vec & ~err_q;

  // A clear in progress removes the arming condition immediately.
  assign byp_arm = (|(err_q & bus.byp_en_mask)) & ~bus.reset_unit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else if (bus.reset_unit) begin
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else if (!first_valid_q && (|new_vec)) begin
      first_valid_q <= 1'b1;
      first_id_q    <= IDW'(lowest_set_idx(32'(new_vec)));
    end
  end

  // One event per edge regardless of how many channels trip together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt_q <= '0;
    end else if ((|new_vec) && (fault_cnt_q != FAULT_CNT_MAX)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btmr      <= '0;
      byp_req_q <= 1'b0;
    end else if (!byp_arm) begin
      btmr <= '0;
    end else if (bus.time_1us && (btmr != BYP_MAX)) begin
      btmr <= btmr + 1'b1;
      if (btmr == BYP_MAX - 1'b1) byp_req_q <= 1'b1;
    end
  end

  assign bus.err_info    = err_q;
  assign bus.err_unit    = |err_q;
  assign bus.first_valid = first_valid_q;
  assign bus.first_id    = first_id_q;
  assign bus.fault_cnt   = fault_cnt_q;
  assign bus.byp_req     = byp_req_q;

endmodule

// File: tb/tb_fault_supervisor.sv
// Directed bench for fault_supervisor with a queue of expected status snapshots.
// Latency: n/a.
// Backpressure: n/a.
module tb_fault_supervisor;
  localparam int N_CH = 12;

  typedef struct {
    string       tag;
    logic [11:0] err;
    logic        fv;
    logic [3:0]  fid;
    logic [7:0]  cnt;
    logic        byp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  fault_supervisor_if #(.N_CH(N_CH)) bus ();

  fault_supervisor #(
    .N_CH       (N_CH),
    .CNT_W      (14),
    .DEB_US     (5),
    .BYP_DLY_US (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [11:0] err, input logic fv,
                              input logic [3:0] fid, input logic [7:0] cnt, input logic byp);
    exp_t e;
    e.tag = tag; e.err = err; e.fv = fv; e.fid = fid; e.cnt = cnt; e.byp = byp;
    sb.push_back(e);
  endtask

  task automatic check_state();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".err_info"},    32'(bus.err_info),    32'(e.err));
      chk({e.tag, ".err_unit"},    32'(bus.err_unit),    32'(|e.err));
      chk({e.tag, ".first_valid"}, 32'(bus.first_valid), 32'(e.fv));
      chk({e.tag, ".first_id"},    32'(bus.first_id),    32'(e.fid));
      chk({e.tag, ".fault_cnt"},   32'(bus.fault_cnt),   32'(e.cnt));
      chk({e.tag, ".byp_req"},     32'(bus.byp_req),     32'(e.byp));
    end
  endtask

  // Each tick is a one-clk strobe followed by one idle clk; inputs change #1 after posedge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      bus.time_1us = 1'b1;
      @(posedge clk); #1;
      bus.time_1us = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_unit();
    bus.reset_unit = 1'b1;
    @(posedge clk); #1;
    bus.reset_unit = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.time_1us = 1'b0;
    bus.reset_unit = 1'b0;
    bus.fault_raw = '0;
    bus.fault_mask = '0;
    bus.byp_en_mask = '0;

    repeat (3) @(posedge clk);
    #1;
    expect_state("reset", 12'h000, 1'b0, 4'd0, 8'd0, 1'b0);
    check_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short pulse of 4 ticks must not latch; a raw-low tick restarts the count.
    bus.fault_raw[3] = 1'b1;
    expect_state("deb_4ticks", 12'h000, 1'b0, 4'd0, 8'd0, 1'b0);
    tick(4); check_state();
    bus.fault_raw = '0;
    tick(1);
    bus.fault_raw[3] = 1'b1;
    expect_state("deb_restart_4", 12'h000, 1'b0, 4'd0, 8'd0, 1'b0);
    tick(4); check_state();
    expect_state("deb_5th_tick", 12'h008, 1'b1, 4'd3, 8'd1, 1'b0);
    tick(1); check_state();
    bus.fault_raw = '0;
    expect_state("clear1", 12'h000, 1'b0, 4'd0, 8'd1, 1'b0);
    clear_unit(); check_state();

    // Two channels on the same edge: lowest index wins, one trip event.
    bus.fault_raw[7] = 1'b1;
    bus.fault_raw[2] = 1'b1;
    expect_state("dual_trip", 12'h084, 1'b1, 4'd2, 8'd2, 1'b0);
    tick(5); check_state();
    bus.fault_raw[0] = 1'b1;
    expect_state("later_ch0", 12'h085, 1'b1, 4'd2, 8'd3, 1'b0);
    tick(5); check_state();
    bus.fault_raw = '0;
    expect_state("clear2", 12'h000, 1'b0, 4'd0, 8'd3, 1'b0);
    clear_unit(); check_state();

    // Clear coincides with the latching tick of channel 4.
    bus.fault_raw[4] = 1'b1;
    tick(4);
    bus.time_1us = 1'b1;
    bus.reset_unit = 1'b1;
    @(posedge clk); #1;
    bus.time_1us = 1'b0;
    bus.reset_unit = 1'b0;
    expect_state("clear_wins", 12'h000, 1'b0, 4'd0, 8'd3, 1'b0);
    check_state();
    // Raw still high after the clear pulse: re-latch after a full debounce.
    expect_state("relatch_4", 12'h000, 1'b0, 4'd0, 8'd3, 1'b0);
    tick(4); check_state();
    expect_state("relatch_5", 12'h010, 1'b1, 4'd4, 8'd4, 1'b0);
    tick(1); check_state();
    bus.fault_raw = '0;
    clear_unit();

    // Masked channel never latches; masking after latch keeps the flag.
    bus.fault_mask[5] = 1'b1;
    bus.fault_raw[5] = 1'b1;
    expect_state("masked_50", 12'h000, 1'b0, 4'd0, 8'd4, 1'b0);
    tick(50); check_state();
    bus.fault_mask[5] = 1'b0;
    expect_state("unmasked", 12'h020, 1'b1, 4'd5, 8'd5, 1'b0);
    tick(5); check_state();
    bus.fault_mask[5] = 1'b1;
    expect_state("mask_after_latch", 12'h020, 1'b1, 4'd5, 8'd5, 1'b0);
    tick(3); check_state();
    bus.fault_raw = '0;
    bus.fault_mask = '0;
    clear_unit();

    // Bypass timer: cleared at tick 999, then full 1000-tick run.
    bus.byp_en_mask[0] = 1'b1;
    bus.fault_raw[0] = 1'b1;
    tick(5);
    bus.fault_raw = '0;
    expect_state("byp_999", 12'h001, 1'b1, 4'd0, 8'd6, 1'b0);
    tick(999); check_state();
    expect_state("byp_cleared", 12'h000, 1'b0, 4'd0, 8'd6, 1'b0);
    clear_unit(); check_state();
    expect_state("byp_after_clr", 12'h000, 1'b0, 4'd0, 8'd6, 1'b0);
    tick(5); check_state();
    bus.fault_raw[0] = 1'b1;
    tick(5);
    bus.fault_raw = '0;
    expect_state("byp_run_999", 12'h001, 1'b1, 4'd0, 8'd7, 1'b0);
    tick(999); check_state();
    expect_state("byp_1000", 12'h001, 1'b1, 4'd0, 8'd7, 1'b1);
    tick(1); check_state();
    expect_state("byp_sticky", 12'h000, 1'b0, 4'd0, 8'd7, 1'b1);
    clear_unit(); check_state();

    // Many trip/clear cycles saturate the trip counter.
    for (int n = 0; n < 300; n++) begin
      bus.fault_raw[1] = 1'b1;
      tick(5);
      bus.fault_raw = '0;
      clear_unit();
    end
    expect_state("cnt_sat", 12'h000, 1'b0, 4'd0, 8'd255, 1'b1);
    check_state();

    // Asynchronous reset mid-debounce, away from any clock edge.
    bus.fault_raw[1] = 1'b1;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 12'h000, 1'b0, 4'd0, 8'd0, 1'b0);
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Debounce count was discarded: 4 more ticks are not enough.
    expect_state("post_rst_4", 12'h000, 1'b0, 4'd0, 8'd0, 1'b0);
    tick(4); check_state();
    expect_state("post_rst_5", 12'h002, 1'b1, 4'd1, 8'd1, 1'b0);
    tick(1); check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
